// File: rtl/tank_gfx_pkg.sv
// Shared tank-game graphics definitions: 12-bit colour type, chroma key and
// the 16-entry tank palette used by every sprite layer.
package tank_gfx_pkg;

    typedef logic [11:0] rgb12_t;

    localparam rgb12_t TRANSPARENT_KEY = 12'hE3F;

    // Listed from index 15 down to index 0.
    localparam rgb12_t [15:0] TANK_PALETTE = {
        12'hE3F, 12'h111, 12'h575, 12'hE3F,
        12'hE3F, 12'h686, 12'h343, 12'hE3F,
        12'h110, 12'h464, 12'h000, 12'hE3F,
        12'hE3F, 12'h7A7, 12'h222, 12'hE3F
    };

    function automatic logic is_opaque(input rgb12_t rgb);
        return (rgb != TRANSPARENT_KEY);
    endfunction

endpackage

// File: rtl/sprite_palette_lut.sv
// Combinational palette expansion: 4-bit sprite index to 12-bit RGB.
module sprite_palette_lut
    import tank_gfx_pkg::*;
(
    input  logic [3:0] index_i,
    output rgb12_t     rgb_o
);

    assign rgb_o = TANK_PALETTE[index_i];

endmodule

// File: rtl/sprite_layer_compositor.sv
// Two-stage sprite compositor: palette expansion and chroma key, then priority
// select over the background. SPRITE_COLLISION_EN adds a layer 0/1 overlap flag.
module sprite_layer_compositor
    import tank_gfx_pkg::*;
#(
    parameter int N_LAYERS = 4
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          pix_en,
    input  logic [N_LAYERS-1:0]           layer_valid,
    input  logic [4*N_LAYERS-1:0]         layer_index,
    input  logic [11:0]                   bg_rgb,
    input  logic                          de_in,
    input  logic                          hs_in,
    input  logic                          vs_in,
    output logic [3:0]                    red,
    output logic [3:0]                    green,
    output logic [3:0]                    blue,
    output logic                          de_out,
    output logic                          hs_out,
    output logic                          vs_out,
    output logic                          hit_valid,
`ifdef SPRITE_COLLISION_EN
    input  logic                          collision_clr,
    output logic                          collision,
`endif
    output logic [$clog2(N_LAYERS)-1:0]   hit_layer
);

    localparam int LAT = 2;
    localparam int HW  = $clog2(N_LAYERS);

    rgb12_t [N_LAYERS-1:0] layer_rgb_s;
    rgb12_t [N_LAYERS-1:0] layer_rgb_q, layer_rgb_d;
    logic   [N_LAYERS-1:0] opaque_q, opaque_d;
    rgb12_t                bg_q, bg_d;
    logic   [LAT-1:0]      de_pipe_q, de_pipe_d;
    logic   [LAT-1:0]      hs_pipe_q, hs_pipe_d;
    logic   [LAT-1:0]      vs_pipe_q, vs_pipe_d;
    rgb12_t                rgb_q, rgb_d;
    logic                  hit_valid_q, hit_valid_d;
    logic   [HW-1:0]       hit_layer_q, hit_layer_d;

    logic                  win_found_s;
    logic   [HW-1:0]       win_idx_s;
    rgb12_t                win_rgb_s;

    for (genvar g = 0; g < N_LAYERS; g++) begin : g_lut
        sprite_palette_lut u_lut (
            .index_i (layer_index[4*g +: 4]),
            .rgb_o   (layer_rgb_s[g])
        );
    end

    // Priority resolve: scanning downwards lets the lowest opaque layer overwrite.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = {HW{1'b0}};
        win_rgb_s   = bg_q;
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            win_found_s = opaque_q[i] ? 1'b1 : win_found_s;
            win_idx_s   = opaque_q[i] ? HW'(i) : win_idx_s;
            win_rgb_s   = opaque_q[i] ? layer_rgb_q[i] : win_rgb_s;
        end
    end

    // Next-state for both pipeline stages; everything holds between strobes.
    always_comb begin
        if (pix_en) begin
            for (int i = 0; i < N_LAYERS; i++) begin
                layer_rgb_d[i] = layer_rgb_s[i];
                opaque_d[i]    = layer_valid[i] && is_opaque(layer_rgb_s[i]);
            end
            bg_d        = bg_rgb;
            de_pipe_d   = {de_pipe_q[LAT-2:0], de_in};
            hs_pipe_d   = {hs_pipe_q[LAT-2:0], hs_in};
            vs_pipe_d   = {vs_pipe_q[LAT-2:0], vs_in};
            rgb_d       = de_pipe_q[0] ? win_rgb_s : 12'h000;
            hit_valid_d = de_pipe_q[0] && win_found_s;
            hit_layer_d = win_idx_s;
        end else begin
            layer_rgb_d = layer_rgb_q;
            opaque_d    = opaque_q;
            bg_d        = bg_q;
            de_pipe_d   = de_pipe_q;
            hs_pipe_d   = hs_pipe_q;
            vs_pipe_d   = vs_pipe_q;
            rgb_d       = rgb_q;
            hit_valid_d = hit_valid_q;
            hit_layer_d = hit_layer_q;
        end
    end

    // Pipeline registers; syncs are active-low so they reset high.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            layer_rgb_q <= '0;
            opaque_q    <= '0;
            bg_q        <= 12'h000;
            de_pipe_q   <= '0;
            hs_pipe_q   <= '1;
            vs_pipe_q   <= '1;
            rgb_q       <= 12'h000;
            hit_valid_q <= 1'b0;
            hit_layer_q <= {HW{1'b0}};
        end else begin
            layer_rgb_q <= layer_rgb_d;
            opaque_q    <= opaque_d;
            bg_q        <= bg_d;
            de_pipe_q   <= de_pipe_d;
            hs_pipe_q   <= hs_pipe_d;
            vs_pipe_q   <= vs_pipe_d;
            rgb_q       <= rgb_d;
            hit_valid_q <= hit_valid_d;
            hit_layer_q <= hit_layer_d;
        end
    end

    assign red       = rgb_q[11:8];
    assign green     = rgb_q[7:4];
    assign blue      = rgb_q[3:0];
    assign de_out    = de_pipe_q[LAT-1];
    assign hs_out    = hs_pipe_q[LAT-1];
    assign vs_out    = vs_pipe_q[LAT-1];
    assign hit_valid = hit_valid_q;
    assign hit_layer = hit_layer_q;

`ifdef SPRITE_COLLISION_EN
    logic collision_q, collision_d;
    logic col_set_s, col_clr_s;

    // Sticky overlap flag: set beats clear, vs falling into stage 2 starts a new frame.
    always_comb begin
        col_set_s = pix_en && opaque_q[0] && opaque_q[1] && de_pipe_q[0];
        col_clr_s = collision_clr || (pix_en && vs_pipe_q[LAT-1] && !vs_pipe_q[LAT-2]);
        if (col_set_s) begin
            collision_d = 1'b1;
        end else if (col_clr_s) begin
            collision_d = 1'b0;
        end else begin
            collision_d = collision_q;
        end
    end

    // Collision flag register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            collision_q <= 1'b0;
        end else begin
            collision_q <= collision_d;
        end
    end

    assign collision = collision_q;
`endif

endmodule

// File: tb/tb_sprite_layer_compositor.sv
// Self-checking bench: directed and random pixels compared against a
// queue-based reference model of the compositor.
module tb_sprite_layer_compositor;

    localparam int N = 4;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          pix_en;
    logic [N-1:0]  layer_valid;
    logic [4*N-1:0] layer_index;
    logic [11:0]   bg_rgb;
    logic          de_in, hs_in, vs_in;
    logic [3:0]    red, green, blue;
    logic          de_out, hs_out, vs_out, hit_valid;
    logic [1:0]    hit_layer;
`ifdef SPRITE_COLLISION_EN
    logic          collision_clr;
    logic          collision;
`endif

    sprite_layer_compositor #(.N_LAYERS(N)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .pix_en      (pix_en),
        .layer_valid (layer_valid),
        .layer_index (layer_index),
        .bg_rgb      (bg_rgb),
        .de_in       (de_in),
        .hs_in       (hs_in),
        .vs_in       (vs_in),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .de_out      (de_out),
        .hs_out      (hs_out),
        .vs_out      (vs_out),
        .hit_valid   (hit_valid),
`ifdef SPRITE_COLLISION_EN
        .collision_clr (collision_clr),
        .collision     (collision),
`endif
        .hit_layer   (hit_layer)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [11:0] rgb;
        logic        de;
        logic        hs;
        logic        vs;
        logic        hv;
        logic [1:0]  hl;
        logic        op0;
        logic        op1;
    } exp_t;

    localparam exp_t RST_E = '{rgb: 12'h000, de: 1'b0, hs: 1'b1, vs: 1'b1,
                               hv: 1'b0, hl: 2'd0, op0: 1'b0, op1: 1'b0};

    logic [11:0] pal [16];
    exp_t        q [$];
    exp_t        cur;
    logic        col_m;
    int          checks = 0;
    int          errors = 0;

    // Expected output for the pixel currently on the inputs.
    function automatic exp_t model();
        exp_t        e;
        int          win;
        logic [11:0] lrgb [N];
        logic        op [N];
        win = -1;
        for (int i = 0; i < N; i++) begin
            lrgb[i] = pal[layer_index[4*i +: 4]];
            op[i]   = layer_valid[i] && (lrgb[i] != 12'hE3F);
            if (op[i] && win < 0) win = i;
        end
        e.de  = de_in;
        e.hs  = hs_in;
        e.vs  = vs_in;
        e.hl  = (win < 0) ? 2'd0 : 2'(win);
        e.hv  = de_in && (win >= 0);
        e.rgb = !de_in ? 12'h000 : ((win < 0) ? bg_rgb : lrgb[win]);
        e.op0 = op[0];
        e.op1 = op[1];
        return e;
    endfunction

    task automatic reset_model();
        q.delete();
        q.push_back(RST_E);
        cur   = RST_E;
        col_m = 1'b0;
    endtask

    task automatic check(input string tag);
        checks++;
        assert ({red, green, blue, de_out, hs_out, vs_out, hit_valid, hit_layer} ===
                {cur.rgb, cur.de, cur.hs, cur.vs, cur.hv, cur.hl})
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag,
                   {red, green, blue, de_out, hs_out, vs_out, hit_valid, hit_layer},
                   {cur.rgb, cur.de, cur.hs, cur.vs, cur.hv, cur.hl});
        end
`ifdef SPRITE_COLLISION_EN
        checks++;
        assert (collision === col_m)
        else begin
            errors++;
            $error("FAIL %s_collision observed=%b expected=%b", tag, collision, col_m);
        end
`endif
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step(input logic en, input string tag);
        exp_t nxt;
        logic clr;
        pix_en = en;
        @(posedge Clk);
`ifdef SPRITE_COLLISION_EN
        clr = collision_clr;
`else
        clr = 1'b0;
`endif
        if (en) begin
            q.push_back(model());
            nxt = q.pop_front();
            if (nxt.op0 && nxt.op1 && nxt.de) col_m = 1'b1;
            else if (clr || (cur.vs && !nxt.vs)) col_m = 1'b0;
            cur = nxt;
        end else if (clr) begin
            col_m = 1'b0;
        end
        #1;
        check(tag);
    endtask

    task automatic rand_inputs();
        layer_valid = 4'($urandom);
        layer_index = 16'($urandom);
        bg_rgb      = 12'($urandom);
        de_in       = ($urandom_range(0, 7) != 0);
        hs_in       = ($urandom_range(0, 9) != 0);
        vs_in       = ($urandom_range(0, 19) != 0);
    endtask

    initial begin
        pal = '{12'hE3F, 12'h222, 12'h7A7, 12'hE3F, 12'hE3F, 12'h000, 12'h464, 12'h110,
                12'hE3F, 12'h343, 12'h686, 12'hE3F, 12'hE3F, 12'h575, 12'h111, 12'hE3F};
        Reset = 1'b1;
        pix_en = 1'b0;
        layer_valid = 4'b0000;
        layer_index = 16'h0000;
        bg_rgb = 12'h000;
        de_in = 1'b0;
        hs_in = 1'b1;
        vs_in = 1'b1;
`ifdef SPRITE_COLLISION_EN
        collision_clr = 1'b0;
`endif
        reset_model();
        #12;
        check("reset");
        chk("reset_hs", 32'(hs_out), 32'd1);
        #1 Reset = 1'b0;

        // Background only.
        bg_rgb = 12'h135;
        de_in  = 1'b1;
        step(1'b1, "bg_s1");
        step(1'b1, "bg_s2");
        chk("bg_rgb", 32'({red, green, blue}), 32'h135);
        chk("bg_hit", 32'(hit_valid), 32'd0);

        // Single opaque layer 2, visible exactly two strobes later.
        layer_valid = 4'b0100;
        layer_index = 16'h0200;
        step(1'b1, "l2_s1");
        step(1'b1, "l2_s2");
        chk("l2_rgb", 32'({red, green, blue}), 32'h7A7);
        chk("l2_layer", 32'({hit_valid, hit_layer}), 32'h6);

        // Transparent layer 0 falls through to layer 1, then opaque layer 0 wins.
        layer_valid = 4'b0011;
        layer_index = 16'h0060;
        step(1'b1, "key_s1");
        step(1'b1, "key_s2");
        chk("key_rgb", 32'({red, green, blue}), 32'h464);
        chk("key_layer", 32'(hit_layer), 32'd1);
        layer_index = 16'h0065;
        step(1'b1, "pri_s1");
        step(1'b1, "pri_s2");
        chk("pri_rgb", 32'({red, green, blue}), 32'h000);
        chk("pri_layer", 32'({hit_valid, hit_layer}), 32'h4);

        // 1-of-2 strobe pattern with a single hs pulse.
        for (int i = 0; i < 16; i++) begin
            rand_inputs();
            hs_in = (i != 5);
            step(1'b0, "gap_hold");
            step(1'b1, "gap_strobe");
        end

        // Random traffic with random strobes.
        for (int i = 0; i < 300; i++) begin
            rand_inputs();
`ifdef SPRITE_COLLISION_EN
            collision_clr = ($urandom_range(0, 15) == 0);
`endif
            step(1'($urandom_range(0, 3) != 0), "rand");
        end
`ifdef SPRITE_COLLISION_EN
        collision_clr = 1'b0;
`endif

        // Asynchronous reset mid-line.
        layer_valid = 4'b0001;
        layer_index = 16'h0002;
        de_in = 1'b1;
        hs_in = 1'b1;
        vs_in = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, "pre_rst");
        #2 Reset = 1'b1;
        #1;
        reset_model();
        check("rst_async");
        chk("rst_de", 32'(de_out), 32'd0);
        pix_en = 1'b1;
        @(posedge Clk);
        #1;
        check("rst_hold");
        #2 Reset = 1'b0;
        step(1'b1, "rel_s1");
        chk("rel_blank", 32'(de_out), 32'd0);
        step(1'b1, "rel_s2");
        chk("rel_pixel", 32'({de_out, red, green, blue}), 32'h17A7);

`ifdef SPRITE_COLLISION_EN
        // Overlap of layers 0 and 1 sets the sticky flag.
        layer_valid = 4'b0011;
        layer_index = 16'h0099;
        for (int i = 0; i < 3; i++) step(1'b1, "col_set");
        chk("col_set", 32'(collision), 32'd1);
        layer_valid = 4'b0000;
        for (int i = 0; i < 3; i++) step(1'b1, "col_stay");
        chk("col_stay", 32'(collision), 32'd1);
        vs_in = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, "col_vs");
        chk("col_vs_clr", 32'(collision), 32'd0);
        vs_in = 1'b1;
        layer_valid = 4'b0011;
        step(1'b1, "col_a");
        layer_valid = 4'b0000;
        collision_clr = 1'b1;
        step(1'b1, "col_b");
        chk("col_set_wins", 32'(collision), 32'd1);
        step(1'b1, "col_c");
        chk("col_clr", 32'(collision), 32'd0);
        collision_clr = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_layer_compositor.md
Name: sprite_layer_compositor

Overview:
- Per-pixel compositor for the tank game video path. Accepts 4-bit palette indices from N_LAYERS sprite layers (tanks, bullets, HUD) and expands each through the shared tank colour palette.
- Resolves priority and chroma-key transparency, then emits one 12-bit RGB pixel with sync and blank delayed to match.
- Sits between the sprite address/ROM logic and the VGA output registers.

Parameters:
- N_LAYERS, 4, number of sprite layers; layer 0 has highest priority.
- LAT, 2, pipeline depth in pix_en strobes; fixed, not user-tunable.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- pix_en  in  1  pixel strobe; the pipeline advances only when this is high.
- layer_valid  in  N_LAYERS  layer i covers the current pixel.
- layer_index  in  4*N_LAYERS  palette index of layer i, at bits [4i+3:4i].
- bg_rgb  in  12  background colour {R,G,B}.
- de_in, hs_in, vs_in  in  1 each  display-enable and syncs, aligned with the indices.
- red, green, blue  out  4 each  composited pixel.
- de_out, hs_out, vs_out  out  1 each  delayed by LAT strobes.
- hit_valid  out  1  some opaque layer won this pixel.
- hit_layer  out  $clog2(N_LAYERS)  winning layer number.

Behaviour:
- Reset state:
  - All pipeline registers 0, so red/green/blue = 0, de_out = 0, hit_valid = 0, hit_layer = 0.
  - hs_out and vs_out reset to 1 (syncs are active-low).
- Stage 1, on Clk when pix_en = 1:
  - Register each layer's palette RGB.
  - opaque[i] = layer_valid[i] && (rgb != TRANSPARENT_KEY).
  - Register bg_rgb, de, hs and vs.
- Stage 2, on Clk when pix_en = 1:
  - Winner is the lowest i with opaque[i].
  - Output that layer's RGB, else bg_rgb; hit_valid = |opaque; hit_layer = winner, or 0 when there is none.
- When the stage-2 de is low: RGB = 0 and hit_valid = 0, regardless of layers.
- Latency is exactly 2 pix_en strobes from input to output.
- With pix_en = 0 all registers hold. pix_en may be tied to 1.
- Reset mid-frame clears the pipeline immediately (asynchronously). The first two strobes after release output blank pixels.
- All N layers transparent or invalid: the background is shown.
- Two or more opaque layers: the lowest index wins, with no blending.

Optional Feature:
- Macro: SPRITE_COLLISION_EN.
- When defined, adds output collision (1 bit) and input collision_clr (1 bit).
- collision sets and stays set when stage 2 sees opaque[0] && opaque[1] with de high.
- collision clears when either of these occurs:
  - the cycle after collision_clr = 1;
  - on the pix_en strobe where the stage-2 vs falls (1→0).
- A set and a clear in the same cycle: set wins. Reset value is 0.
- When the macro is undefined: neither port exists and no collision logic is built.

Decomposition:
- Package tank_gfx_pkg holds:
  - typedef rgb12_t (logic [11:0]);
  - constant TRANSPARENT_KEY = 12'hE3F;
  - the 16-entry tank palette constant.
- Palette entries:
  - Indices 0, 3, 4, 8, 11, 12 and 15 are E3F.
  - 1 = 222, 2 = 7A7, 5 = 000, 6 = 464, 7 = 110, 9 = 343, 10 = 686, 13 = 575, 14 = 111.
- Sub-module sprite_palette_lut: a combinational 4-bit index to rgb12_t lookup from the package table. Instantiate it N_LAYERS times via generate.

Test Plan:
- Reset, then pix_en = 1, layer_valid = 0, bg_rgb = 0x135, de_in = 1 → after 2 strobes RGB = 1/3/5, hit_valid = 0.
- Layer 2 valid with index 2, others invalid → RGB = 7/A/7, hit_layer = 2, hit_valid = 1, exactly 2 strobes later.
- Layers 0 and 1 valid, layer 0 index 0 (transparent), layer 1 index 6 → RGB = 4/6/4, hit_layer = 1; then layer 0 index 5 → RGB = 0/0/0, hit_layer = 0.
- Toggle pix_en in a 1-of-2 pattern with hs_in pulsed low once → hs_out goes low exactly 2 strobes later; outputs hold between strobes.
- Assert Reset mid-line with opaque data flowing → outputs 0 and de_out = 0 at once; the first valid pixel appears on the 2nd strobe after release.
- SPRITE_COLLISION_EN: layers 0 and 1 both index 9 with de = 1 → collision = 1 and stays set; a vs falling edge clears it; simultaneous overlap and collision_clr leaves it at 1.
